// File: rtl/door_input_debounce_pkg.sv
// Shared definitions for the door input debounce stage: FSM encoding and default timing.
package door_input_debounce_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } db_state_e;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_CNT_W           = 20;

endpackage

// File: rtl/door_input_debounce_channel.sv
// One switch channel: 2-flop synchroniser feeding a counter-qualified debounce FSM.
module door_input_debounce_channel
  import door_input_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic flip
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;
  db_state_e        state;

  // Asserted on the edge where level toggles; the top registers it into change.
  assign flip = (state == ST_CHECK) && (s2 != level) && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      state <= ST_STABLE;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      case (state)
        ST_STABLE: begin
          if (s2 != level) begin
            state <= ST_CHECK;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        ST_CHECK: begin
          if (s2 == level) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            level <= ~level;
            state <= ST_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/door_input_debounce.sv
// Debounces the two raw door switches into clean A/B levels plus a one-cycle change strobe.
module door_input_debounce
  import door_input_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_a,
  input  logic sw_b,
  output logic A,
  output logic B,
  output logic change
);

  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0] raw, lvl, flp;

  assign raw = {sw_b, sw_a};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    door_input_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[c]),
      .level(lvl[c]),
      .flip (flp[c])
    );
  end

  assign A = lvl[0];
  assign B = lvl[1];

  // Simultaneous flips collapse into a single pulse aligned with the new levels.
  always_ff @(posedge clk) begin
    if (rst) change <= 1'b0;
    else     change <= |flp;
  end

endmodule

// File: tb/tb_door_input_debounce.sv
// Random and directed stimulus against a run-length reference model of the debouncer.
module tb_door_input_debounce;

  localparam int D  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_a = 1'b0;
  logic sw_b = 1'b0;
  logic A, B, change;

  always #5 clk = ~clk;

  door_input_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .sw_a(sw_a), .sw_b(sw_b),
    .A(A), .B(B), .change(change)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each output sees the raw input two edges late, and flips once it has
  // disagreed with the output on D+1 consecutive edges.
  bit dq_old [2];
  bit dq_new [2];
  bit m_out  [2];
  int run    [2];
  bit m_chg  = 1'b0;
  bit live   = 1'b0;

  always @(posedge clk) begin
    bit fl, raw, v;
    fl = 1'b0;
    for (int c = 0; c < 2; c++) begin
      raw = (c == 0) ? sw_a : sw_b;
      if (rst) begin
        dq_old[c] = 1'b0;
        dq_new[c] = 1'b0;
        m_out[c]  = 1'b0;
        run[c]    = 0;
      end else begin
        v         = dq_old[c];
        dq_old[c] = dq_new[c];
        dq_new[c] = raw;
        if (v != m_out[c]) begin
          run[c]++;
          if (run[c] == D + 1) begin
            m_out[c] = ~m_out[c];
            run[c]   = 0;
            fl       = 1'b1;
          end
        end else begin
          run[c] = 0;
        end
      end
    end
    m_chg = rst ? 1'b0 : fl;
    if (rst) live = 1'b1;
  end

  int pulses = 0;

  always @(negedge clk) begin
    if (live) begin
      chk("A", 32'(A), 32'(m_out[0]));
      chk("B", 32'(B), 32'(m_out[1]));
      chk("change", 32'(change), 32'(m_chg));
      if (change === 1'b1) pulses++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    // reset held with switches high
    rst = 1'b1; sw_a = 1'b1; sw_b = 1'b1;
    cyc(3);
    chk("rst_A", 32'(A), 32'd0);
    chk("rst_B", 32'(B), 32'd0);
    chk("rst_change", 32'(change), 32'd0);
    base = pulses;
    rst = 1'b0;
    cyc(10);
    chk("post_rst_pulses", 32'(pulses - base), 32'd1);

    // single channel rise
    sw_a = 1'b0; sw_b = 1'b0; cyc(10);
    sw_a = 1'b1; cyc(10);
    chk("rise_A", 32'(A), 32'd1);
    chk("rise_B", 32'(B), 32'd0);

    // bouncing shorter than the qualify window never reaches A
    for (int i = 0; i < 6; i++) begin
      sw_a = (i % 2 == 0); cyc(2);
    end
    chk("bounce_hold", 32'(A), 32'd1);
    sw_a = 1'b0; cyc(10);
    chk("settle_A", 32'(A), 32'd0);

    // simultaneous rise -> one pulse
    base = pulses;
    sw_a = 1'b1; sw_b = 1'b1; cyc(10);
    chk("simul_pulses", 32'(pulses - base), 32'd1);

    // reset mid-count on channel b
    sw_a = 1'b0; sw_b = 1'b0; cyc(10);
    sw_b = 1'b1; cyc(5);
    rst = 1'b1; cyc(1);
    rst = 1'b0;
    chk("midcnt_B", 32'(B), 32'd0);
    cyc(10);
    chk("requal_B", 32'(B), 32'd1);

    // walk 00,01,10,11 starting from settled 11
    sw_a = 1'b1; sw_b = 1'b1; cyc(10);
    base = pulses;
    for (int p = 0; p < 4; p++) begin
      sw_a = p[1]; sw_b = p[0]; cyc(10);
    end
    cyc(2);
    chk("walk_pulses", 32'(pulses - base), 32'd4);

    // randomized bounce patterns, occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1; cyc($urandom_range(1, 2)); rst = 1'b0;
      end
      sw_a = 1'($urandom);
      sw_b = 1'($urandom);
      cyc($urandom_range(0, 3) == 0 ? $urandom_range(6, 12) : $urandom_range(1, 6));
    end
    cyc(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
